quad_encoder_counter: RTL and testbench
=======================================

Name: quad_encoder_counter

Overview:
- Quadrature wheel-encoder front end. One instance per wheel; produces the 24-bit positive-only tic count and direction bit consumed by the PID loop as feedback_cnt1/2 and wheel_dir_1/2.
- Accepts the PID's zero_encoders request and the sample-mode on/off flag.
- Provides sync, glitch filtering, 4x decoding, saturating count, and error flags.

Parameters:
- CNT_W, 24: tic counter width.
- FILT_LEN, 4: consecutive stable clocks required before a synced A/B level is accepted (1..15).
- INVERT_DIR, 0: 1 swaps the forward/reverse sense, for a mirrored wheel.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: asynchronous active-low reset.
- enc_a, input, 1: encoder channel A, asynchronous pin.
- enc_b, input, 1: encoder channel B, asynchronous pin.
- count_en, input, 1: count gate; driven by sampleFlag in sample mode, otherwise tied high.
- zero_cnt, input, 1: synchronous clear request; wired from zero_encoders.
- feedback_cnt, output, CNT_W: tics since the last zero, unsigned.
- wheel_dir, output, 1: direction of the last valid step; fwd = 0, rev = 1.
- step_pulse, output, 1: one-cycle strobe on each counted tic.
- cnt_ovf, output, 1: sticky flag; the counter has saturated.
- illegal_err, output, 1: sticky flag; a double transition was seen.

Behaviour:
- Reset, async assert with synchronous deassert use: all outputs are 0, decoder is uninitialised, filters are cleared.
- Synchronisation: each channel passes through 2 flip-flops.
- Filter:
  - A per-channel stability counter restarts whenever the synced level changes.
  - The filtered level updates only after FILT_LEN consecutive equal samples.
  - Pulses shorter than FILT_LEN clocks are never seen by the decoder.
- Decoder state: prev_ab holds the last filtered {A,B}.
  - After reset, the first filtered sample only loads prev_ab; no count.
  - Forward sequence: 00->01->11->10->00.
  - Reverse sequence: 00->10->11->01->00.
  - Each valid step asserts step_pulse for 1 cycle, adds +1 to feedback_cnt (both directions, since the count is a magnitude), and updates wheel_dir.
  - Illegal step (both bits change): no count, wheel_dir unchanged, illegal_err sets; prev_ab still updates.
- Latency: an enc_a/enc_b edge that stays stable produces feedback_cnt and step_pulse changes exactly FILT_LEN+3 clocks later.
- count_en low:
  - Steps are not counted and step_pulse stays low.
  - prev_ab keeps tracking, so re-enabling never produces a phantom step.
  - feedback_cnt holds.
- zero_cnt high: on that edge feedback_cnt becomes 0 and cnt_ovf and illegal_err clear; held high, the count stays 0.
- Simultaneous zero_cnt and valid step: zero wins and the step is dropped; step_pulse still asserts, wheel_dir still updates.
- Saturation: at 2^CNT_W-1 further steps leave the count unchanged and set cnt_ovf. No wrap-around, because the PID's differences assume none.
- wheel_dir is not affected by zero_cnt or count_en.

Optional Feature:
- Macro: QENC_DIR_ZERO_EN.
- Defined: a valid step whose direction differs from the current wheel_dir clears feedback_cnt to 1 (the reversing tic counts) in the same cycle. This performs the automatic encoder zeroing the PID needs on direction reversal. zero_cnt still has priority.
- Undefined: reversal only toggles wheel_dir; the count continues to accumulate.

Decomposition:
- Shared package qenc_pkg holds:
  - DIR_FWD = 1'b0 and DIR_REV = 1'b1.
  - Default CNT_W = 24.
  - Quadrature step lookup constants (forward/reverse/none/illegal encoding of {prev_ab, new_ab}).
- Sub-module enc_input_filter: 2-FF sync plus FILT_LEN stability counter for one channel, instantiated twice.

Test Plan:
- Forward steps: FILT_LEN=4; apply 8 forward quadrature steps, 20 clocks apart -> feedback_cnt=8, wheel_dir=0, each step_pulse exactly 7 clocks after its edge, illegal_err=0.
- Glitch rejection: 3-clock pulse on enc_a -> no step_pulse, count unchanged. Then a 4-clock-stable change -> count increments once.
- Illegal transition: drive 00->11 -> illegal_err=1, count unchanged. Next legal step counts. Then pulse zero_cnt -> count=0, illegal_err=0.
- Zero collision and gating:
  - zero_cnt asserted in the same cycle as a step's update with count=5 -> count=0, step_pulse=1.
  - count_en=0 during 3 steps -> count holds.
  - re-enable -> no phantom count.
- Saturation: CNT_W=4, 17 forward steps -> count=15, cnt_ovf=1; zero_cnt clears both.
- Reversal and reset:
  - 5 forward steps then 3 reverse -> macro off: count=8, wheel_dir=1; QENC_DIR_ZERO_EN: count=3, wheel_dir=1.
  - rst_n pulsed mid-sequence -> all outputs 0 asynchronously, first post-reset sample not counted.

Source files
------------

// File: rtl/qenc_pkg.sv
// Shared constants for the quadrature encoder front end: direction encoding,
// default counter width and the {prev_ab, new_ab} step lookup.
package qenc_pkg;

    localparam logic DIR_FWD   = 1'b0;
    localparam logic DIR_REV   = 1'b1;
    localparam int   CNT_W_DEF = 24;

    typedef enum logic [1:0] {
        STEP_NONE = 2'd0,
        STEP_FWD  = 2'd1,
        STEP_REV  = 2'd2,
        STEP_ILL  = 2'd3
    } step_t;

    typedef enum logic {
        DEC_UNINIT = 1'b0,
        DEC_TRACK  = 1'b1
    } dec_state_t;

    // Forward is 00->01->11->10->00; both bits changing is a lost step.
    function automatic step_t decode_step(input logic [1:0] prev_ab,
                                          input logic [1:0] new_ab);
        case ({prev_ab, new_ab})
            4'b0001, 4'b0111, 4'b1110, 4'b1000: return STEP_FWD;
            4'b0010, 4'b1011, 4'b1101, 4'b0100: return STEP_REV;
            4'b0000, 4'b0101, 4'b1111, 4'b1010: return STEP_NONE;
            default:                            return STEP_ILL;
        endcase
    endfunction

endpackage

// File: rtl/enc_input_filter.sv
// One encoder channel: 2-FF synchroniser followed by a stability filter that
// accepts a level only after FILT_LEN consecutive equal synced samples.
module enc_input_filter #(
    parameter int FILT_LEN = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout,
    output logic valid
);

    logic [1:0] sync_q;
    logic       last_q;
    logic [3:0] stab_q;
    logic [3:0] stab_nxt;

    always_comb begin
        stab_nxt = stab_q;
        if (sync_q[1] != last_q) begin
            stab_nxt = 4'd1;
        end else if (stab_q < 4'(FILT_LEN)) begin
            stab_nxt = stab_q + 4'd1;
        end
    end

    // valid marks that at least one level has been accepted since reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
            last_q <= 1'b0;
            stab_q <= 4'd0;
            dout   <= 1'b0;
            valid  <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], din};
            last_q <= sync_q[1];
            stab_q <= stab_nxt;
            if (stab_nxt == 4'(FILT_LEN)) begin
                dout  <= sync_q[1];
                valid <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/quad_encoder_counter.sv
// Quadrature wheel-encoder front end: filtered 4x decode into a saturating tic
// magnitude. Define QENC_DIR_ZERO_EN to restart the count on direction reversal.
module quad_encoder_counter
    import qenc_pkg::*;
#(
    parameter int CNT_W      = CNT_W_DEF,
    parameter int FILT_LEN   = 4,
    parameter bit INVERT_DIR = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enc_a,
    input  logic             enc_b,
    input  logic             count_en,
    input  logic             zero_cnt,
    output logic [CNT_W-1:0] feedback_cnt,
    output logic             wheel_dir,
    output logic             step_pulse,
    output logic             cnt_ovf,
    output logic             illegal_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic       filt_a, filt_b;
    logic       valid_a, valid_b;
    logic [1:0] filt_ab;
    logic [1:0] prev_ab_q;
    dec_state_t state_q, state_nxt;
    step_t      step;
    logic       step_valid;
    logic       step_dir;
    logic       count_step;
    logic       dir_clear;

    enc_input_filter #(.FILT_LEN(FILT_LEN)) u_filt_a (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (enc_a),
        .dout  (filt_a),
        .valid (valid_a)
    );

    enc_input_filter #(.FILT_LEN(FILT_LEN)) u_filt_b (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (enc_b),
        .dout  (filt_b),
        .valid (valid_b)
    );

    assign filt_ab = {filt_a, filt_b};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= DEC_UNINIT;
        else        state_q <= state_nxt;
    end

    // The first accepted sample after reset only seeds prev_ab.
    always_comb begin
        state_nxt = state_q;
        step      = STEP_NONE;
        case (state_q)
            DEC_UNINIT: if (valid_a && valid_b) state_nxt = DEC_TRACK;
            DEC_TRACK:  step = decode_step(prev_ab_q, filt_ab);
            default:    state_nxt = DEC_UNINIT;
        endcase
        step_valid = (step == STEP_FWD) || (step == STEP_REV);
        step_dir   = ((step == STEP_REV) ? DIR_REV : DIR_FWD) ^ INVERT_DIR;
        count_step = step_valid && count_en;
`ifdef QENC_DIR_ZERO_EN
        dir_clear  = (step_dir != wheel_dir);
`else
        dir_clear  = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_ab_q    <= 2'b00;
            feedback_cnt <= '0;
            wheel_dir    <= DIR_FWD;
            step_pulse   <= 1'b0;
            cnt_ovf      <= 1'b0;
            illegal_err  <= 1'b0;
        end else begin
            prev_ab_q  <= filt_ab;
            step_pulse <= count_step;
            if (step_valid) wheel_dir <= step_dir;
            // Zero request beats any step landing in the same cycle.
            if (zero_cnt) begin
                feedback_cnt <= '0;
                cnt_ovf      <= 1'b0;
                illegal_err  <= 1'b0;
            end else begin
                if (step == STEP_ILL) illegal_err <= 1'b1;
                if (count_step) begin
                    if (dir_clear)                   feedback_cnt <= CNT_W'(1);
                    else if (feedback_cnt == CNT_MAX) cnt_ovf     <= 1'b1;
                    else                             feedback_cnt <= feedback_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_quad_encoder_counter.sv
// Directed + randomized bench for quad_encoder_counter: a 24-bit instance and a
// 4-bit instance share stimulus; a step-level model predicts counts and flags.
module tb_quad_encoder_counter;

  localparam int FILT_LEN = 4;
  localparam int LAT      = FILT_LEN + 3;
  localparam int WIN      = LAT + 3;
  localparam int CNT_W    = 24;
  localparam int SAT_W    = 4;
  localparam int CNT_MAXV = (1 << CNT_W) - 1;
  localparam int SAT_MAXV = (1 << SAT_W) - 1;
`ifdef QENC_DIR_ZERO_EN
  localparam bit DIR_ZERO = 1'b1;
`else
  localparam bit DIR_ZERO = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic enc_a, enc_b, count_en, zero_cnt;
  logic [CNT_W-1:0] feedback_cnt;
  logic wheel_dir, step_pulse, cnt_ovf, illegal_err;
  logic [SAT_W-1:0] sat_cnt;
  logic sat_dir, sat_pulse, sat_ovf, sat_ill;

  int total = 0;
  int bad   = 0;

  // behavioural model: position on the gray cycle plus per-instance counts
  logic [1:0] gray [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
  int   m_pos;
  int   m_cnt, m_sat;
  logic m_dir, m_ovf, m_sat_ovf, m_ill;

  // clock/reset block
  always #5 clk = ~clk;

  quad_encoder_counter #(.CNT_W(CNT_W), .FILT_LEN(FILT_LEN), .INVERT_DIR(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .enc_a(enc_a), .enc_b(enc_b),
    .count_en(count_en), .zero_cnt(zero_cnt),
    .feedback_cnt(feedback_cnt), .wheel_dir(wheel_dir), .step_pulse(step_pulse),
    .cnt_ovf(cnt_ovf), .illegal_err(illegal_err)
  );

  quad_encoder_counter #(.CNT_W(SAT_W), .FILT_LEN(FILT_LEN), .INVERT_DIR(1'b0)) dut_sat (
    .clk(clk), .rst_n(rst_n), .enc_a(enc_a), .enc_b(enc_b),
    .count_en(count_en), .zero_cnt(zero_cnt),
    .feedback_cnt(sat_cnt), .wheel_dir(sat_dir), .step_pulse(sat_pulse),
    .cnt_ovf(sat_ovf), .illegal_err(sat_ill)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag);
    chk({tag, "_cnt"},     32'(feedback_cnt), 32'(m_cnt));
    chk({tag, "_dir"},     32'(wheel_dir),    32'(m_dir));
    chk({tag, "_ovf"},     32'(cnt_ovf),      32'(m_ovf));
    chk({tag, "_ill"},     32'(illegal_err),  32'(m_ill));
    chk({tag, "_sat_cnt"}, 32'(sat_cnt),      32'(m_sat));
    chk({tag, "_sat_ovf"}, 32'(sat_ovf),      32'(m_sat_ovf));
  endtask

  task automatic model_zero();
    m_cnt = 0; m_sat = 0; m_ovf = 1'b0; m_sat_ovf = 1'b0; m_ill = 1'b0;
  endtask

  task automatic model_step(input bit rev, input bit en, input bit zero);
    if (zero) begin
      model_zero();
    end else if (en) begin
      if (DIR_ZERO && (rev != m_dir)) begin
        m_cnt = 1; m_sat = 1;
      end else begin
        if (m_cnt == CNT_MAXV) m_ovf = 1'b1; else m_cnt++;
        if (m_sat == SAT_MAXV) m_sat_ovf = 1'b1; else m_sat++;
      end
    end
    m_dir = rev;
  endtask

  // driver: one quadrature step; zmode 0 = none, 1 = zero on the update edge, 2 = zero held
  task automatic do_step(input string tag, input bit rev, input bit en, input int zmode);
    int pulses, sat_pulses, first_k;
    pulses = 0; sat_pulses = 0; first_k = 0;
    count_en = en;
    m_pos = rev ? (m_pos + 3) % 4 : (m_pos + 1) % 4;
    {enc_a, enc_b} = gray[m_pos];
    if (zmode == 2) zero_cnt = 1'b1;
    for (int k = 1; k <= WIN; k++) begin
      @(posedge clk); #1;
      if (step_pulse) begin
        pulses++;
        if (first_k == 0) first_k = k;
      end
      if (sat_pulse) sat_pulses++;
      if (zmode == 1 && k == LAT - 1) zero_cnt = 1'b1;
      if (zmode == 1 && k == LAT) zero_cnt = 1'b0;
    end
    zero_cnt = 1'b0;
    model_step(rev, en, zmode != 0);
    chk({tag, "_pulses"},     32'(pulses),     en ? 32'd1 : 32'd0);
    chk({tag, "_sat_pulses"}, 32'(sat_pulses), en ? 32'd1 : 32'd0);
    if (en) chk({tag, "_latency"}, 32'(first_k), 32'(LAT));
    chk_state(tag);
    repeat ($urandom_range(0, 4)) @(posedge clk);
    #1;
  endtask

  task automatic do_illegal(input string tag);
    int pulses;
    pulses = 0;
    m_pos = (m_pos + 2) % 4;
    {enc_a, enc_b} = gray[m_pos];
    for (int k = 1; k <= WIN; k++) begin
      @(posedge clk); #1;
      if (step_pulse || sat_pulse) pulses++;
    end
    m_ill = 1'b1;
    chk({tag, "_pulses"}, 32'(pulses), 32'd0);
    chk_state(tag);
  endtask

  task automatic do_zero(input string tag);
    zero_cnt = 1'b1;
    @(posedge clk); #1;
    zero_cnt = 1'b0;
    model_zero();
    chk_state(tag);
  endtask

  task automatic idle_check(input string tag, input int n);
    int pulses;
    pulses = 0;
    repeat (n) begin
      @(posedge clk); #1;
      if (step_pulse || sat_pulse) pulses++;
    end
    chk({tag, "_pulses"}, 32'(pulses), 32'd0);
    chk_state(tag);
  endtask

  task automatic do_glitch(input string tag, input int len);
    enc_a = ~enc_a;
    repeat (len) @(posedge clk);
    #1;
    enc_a = ~enc_a;
    idle_check(tag, WIN + 2);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cnt"},   32'(feedback_cnt), 32'd0);
    chk({tag, "_dir"},   32'(wheel_dir),    32'd0);
    chk({tag, "_pulse"}, 32'(step_pulse),   32'd0);
    chk({tag, "_ovf"},   32'(cnt_ovf),      32'd0);
    chk({tag, "_ill"},   32'(illegal_err),  32'd0);
    chk({tag, "_sat"},   32'(sat_cnt),      32'd0);
  endtask

  initial begin
    int n_rand;
    rst_n = 1'b0; zero_cnt = 1'b0; count_en = 1'b1;
    m_pos = 0; {enc_a, enc_b} = gray[0];
    model_zero(); m_dir = 1'b0;
    #3;
    chk_all_zero("reset");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle_check("post_reset", 12);

    // forward steps
    for (int i = 0; i < 8; i++) do_step("fwd", 1'b0, 1'b1, 0);
    chk("fwd8_total", 32'(feedback_cnt), 32'd8);
    chk("fwd8_dir", 32'(wheel_dir), 32'd0);

    // glitch rejection, then a real change
    do_glitch("glitch3", FILT_LEN - 1);
    do_glitch("glitch1", 1);
    do_step("after_glitch", 1'b0, 1'b1, 0);
    chk("after_glitch_total", 32'(feedback_cnt), 32'd9);

    // illegal transition
    do_illegal("illegal");
    do_step("post_illegal", 1'b0, 1'b1, 0);
    do_zero("zero_after_ill");

    // zero held through a step, then collision with count=5
    do_step("zero_held", 1'b0, 1'b1, 2);
    for (int i = 0; i < 5; i++) do_step("pre_collide", 1'b0, 1'b1, 0);
    chk("pre_collide_total", 32'(feedback_cnt), 32'd5);
    do_step("collide", 1'b0, 1'b1, 1);
    chk("collide_total", 32'(feedback_cnt), 32'd0);

    // gating
    do_step("gate_pre", 1'b1, 1'b1, 0);
    for (int i = 0; i < 3; i++) do_step("gated", 1'b1, 1'b0, 0);
    count_en = 1'b1;
    idle_check("reenable", WIN);
    do_step("reenable_step", 1'b1, 1'b1, 0);

    // saturation of the 4-bit instance
    do_zero("sat_zero");
    for (int i = 0; i < 17; i++) do_step("sat", 1'b0, 1'b1, 0);
    chk("sat_total", 32'(sat_cnt), 32'd15);
    chk("sat_flag", 32'(sat_ovf), 32'd1);
    chk("sat_wide_total", 32'(feedback_cnt), 32'd17);
    do_zero("sat_clear");

    // reversal
    for (int i = 0; i < 5; i++) do_step("rev_fwd", 1'b0, 1'b1, 0);
    for (int i = 0; i < 3; i++) do_step("rev_rev", 1'b1, 1'b1, 0);
    chk("reversal_total", 32'(feedback_cnt), DIR_ZERO ? 32'd3 : 32'd8);
    chk("reversal_dir", 32'(wheel_dir), 32'd1);

    // reset in the middle of a step
    m_pos = (m_pos + 1) % 4;
    {enc_a, enc_b} = gray[m_pos];
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_zero(); m_dir = 1'b0;
    idle_check("mid_reset_first_sample", WIN + 6);
    do_step("mid_reset_next", 1'b1, 1'b1, 0);
    chk("mid_reset_next_total", 32'(feedback_cnt), 32'd1);

    // randomized mix
    n_rand = 40;
    for (int i = 0; i < n_rand; i++) begin
      int sel;
      sel = $urandom_range(0, 19);
      if (sel == 0) do_illegal("rand_ill");
      else if (sel == 1) do_zero("rand_zero");
      else if (sel == 2) do_glitch("rand_glitch", $urandom_range(1, FILT_LEN - 1));
      else do_step("rand", 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
                   ($urandom_range(0, 9) == 0) ? 1 : 0);
    end
    count_en = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
